// File: rtl/req_slots_pkg.sv
// rtl/req_slots_pkg.sv - shared slot state encoding and popcount helper
// Contents:
//   slot_state_e : per-slot lifecycle EMPTY -> PENDING -> DONE
//   popcount     : number of set bits in a 32-bit vector
package req_slots_pkg;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_DONE    = 2'd2
  } slot_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/req_slots_if.sv
// rtl/req_slots_if.sv - requester and selector facing signals of req_slots
// Signals:
//   req_valid/req_ready/req_data    : request handshake, one lane per port
//   resp_valid/resp_ready/resp_data : result handshake, one lane per port
//   pending/slot_data               : to the selector inb/ins inputs
//   done/result                     : from the selector completion/outs
// Modports: master = requesters + selector, slave = req_slots
interface req_slots_if #(
  parameter int  NumPorts = 4,
  parameter type T        = logic [7:0],
  parameter type O        = logic [7:0]
);

  logic [NumPorts-1:0] req_valid;
  logic [NumPorts-1:0] req_ready;
  T                    req_data  [NumPorts];
  logic [NumPorts-1:0] resp_valid;
  logic [NumPorts-1:0] resp_ready;
  O                    resp_data [NumPorts];
  logic [NumPorts-1:0] pending;
  T                    slot_data [NumPorts];
  logic [NumPorts-1:0] done;
  O                    result    [NumPorts];

  modport master (
    output req_valid, req_data, resp_ready, done, result,
    input  req_ready, resp_valid, resp_data, pending, slot_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready, done, result,
    output req_ready, resp_valid, resp_data, pending, slot_data
  );

endinterface

// File: rtl/req_slot.sv
// rtl/req_slot.sv - one request slot: state machine, payload registers, age counter
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready/req_data     : request handshake
//   resp_valid/resp_ready/resp_data  : result handshake
//   pending/slot_data                : to selector
//   done/result                      : from selector
//   flush                            : drop a PENDING request
//   starve                           : pending for StarveLimit cycles
//   busy                             : slot is not EMPTY
//   done_err                         : done seen while not PENDING
module req_slot
  import req_slots_pkg::*;
#(
  parameter type T           = logic [7:0],
  parameter type O           = logic [7:0],
  parameter int  StarveLimit = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  T     req_data,
  output logic resp_valid,
  input  logic resp_ready,
  output O     resp_data,
  output logic pending,
  output T     slot_data,
  input  logic done,
  input  O     result,
  input  logic flush,
  output logic starve,
  output logic busy,
  output logic done_err
);

  localparam int AgeW = $clog2(StarveLimit + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(StarveLimit);

  slot_state_e     state, state_nxt;
  logic            accept;
  logic [AgeW-1:0] age;

  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_EMPTY;
    else     state <= state_nxt;
  end

  // accept marks every entry into PENDING, from EMPTY or from a drained DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        if (req_valid) begin
          state_nxt = SLOT_PENDING;
          accept    = 1'b1;
        end
      end
      SLOT_PENDING: begin
        // done outranks flush so a completed result is never lost
        if (done)       state_nxt = SLOT_DONE;
        else if (flush) state_nxt = SLOT_EMPTY;
      end
      SLOT_DONE: begin
        if (resp_ready) begin
          if (req_valid) begin
            state_nxt = SLOT_PENDING;
            accept    = 1'b1;
          end else begin
            state_nxt = SLOT_EMPTY;
          end
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_data <= '0;
      resp_data <= '0;
    end else begin
      if (accept)                         slot_data <= req_data;
      if (state == SLOT_PENDING && done)  resp_data <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                            age <= '0;
    else if (accept)                                    age <= '0;
    else if (state == SLOT_PENDING && age != AgeMax)    age <= age + 1'b1;
  end

  assign req_ready  = (state == SLOT_EMPTY) || (state == SLOT_DONE && resp_ready);
  assign pending    = (state == SLOT_PENDING);
  assign resp_valid = (state == SLOT_DONE);
  assign starve     = (state == SLOT_PENDING) && (age == AgeMax);
  assign busy       = (state != SLOT_EMPTY);
  assign done_err   = done && (state != SLOT_PENDING);

endmodule

// File: rtl/req_slots.sv
// rtl/req_slots.sv - per-port request holding stage in front of the priority selector
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : req_slots_if.slave (request/response handshakes, selector side)
//   flush       : drop all PENDING requests
//   outstanding : number of non-EMPTY slots
//   starve      : per-port starvation flags
//   proto_err   : sticky, done seen on a slot that was not PENDING
module req_slots
  import req_slots_pkg::*;
#(
  parameter int  NumPorts    = 4,
  parameter type T           = logic [7:0],
  parameter type O           = logic [7:0],
  parameter int  StarveLimit = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  req_slots_if.slave                    bus,
  input  logic                          flush,
  output logic [$clog2(NumPorts+1)-1:0] outstanding,
  output logic [NumPorts-1:0]           starve,
  output logic                          proto_err
);

  localparam int CntW = $clog2(NumPorts + 1);

  logic [NumPorts-1:0] busy;
  logic [NumPorts-1:0] done_err;

  for (genvar g = 0; g < NumPorts; g++) begin : g_slot
    req_slot #(
      .T           (T),
      .O           (O),
      .StarveLimit (StarveLimit)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (bus.req_valid[g]),
      .req_ready  (bus.req_ready[g]),
      .req_data   (bus.req_data[g]),
      .resp_valid (bus.resp_valid[g]),
      .resp_ready (bus.resp_ready[g]),
      .resp_data  (bus.resp_data[g]),
      .pending    (bus.pending[g]),
      .slot_data  (bus.slot_data[g]),
      .done       (bus.done[g]),
      .result     (bus.result[g]),
      .flush      (flush),
      .starve     (starve[g]),
      .busy       (busy[g]),
      .done_err   (done_err[g])
    );
  end

  assign outstanding = CntW'(popcount(32'(busy)));

  always_ff @(posedge clk) begin
    if (rst)            proto_err <= 1'b0;
    else if (|done_err) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_req_slots.sv
// tb/tb_req_slots.sv - self-checking bench for req_slots against a slot-level reference model
module tb_req_slots;
  localparam int N = 4;
  localparam int L = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [2:0]   outstanding;
  logic [N-1:0] starve;
  logic         proto_err;

  always #5 clk = ~clk;

  req_slots_if #(.NumPorts(N), .T(logic [7:0]), .O(logic [7:0])) bus ();

  req_slots #(
    .NumPorts    (N),
    .T           (logic [7:0]),
    .O           (logic [7:0]),
    .StarveLimit (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .outstanding (outstanding),
    .starve      (starve),
    .proto_err   (proto_err)
  );

  // model: 0 = empty, 1 = waiting for service, 2 = result held
  int         m_st  [N];
  logic [7:0] m_pay [N];
  logic [7:0] m_res [N];
  int         m_age [N];
  logic       m_perr;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_st[k] = 0; m_pay[k] = 8'h00; m_res[k] = 8'h00; m_age[k] = 0;
    end
    m_perr = 1'b0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_st[k] != 1 && bus.done[k]) m_perr = 1'b1;
        if (m_st[k] == 0) begin
          if (bus.req_valid[k]) begin m_st[k] = 1; m_pay[k] = bus.req_data[k]; m_age[k] = 0; end
        end else if (m_st[k] == 1) begin
          if (bus.done[k])  begin m_st[k] = 2; m_res[k] = bus.result[k]; end
          else if (flush)   m_st[k] = 0;
          else if (m_age[k] < L) m_age[k] = m_age[k] + 1;
        end else begin
          if (bus.resp_ready[k]) begin
            if (bus.req_valid[k]) begin m_st[k] = 1; m_pay[k] = bus.req_data[k]; m_age[k] = 0; end
            else m_st[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_rdy, e_pend, e_rv, e_stv;
    int cnt;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      e_rdy[k]  = (m_st[k] == 0) || (m_st[k] == 2 && bus.resp_ready[k]);
      e_pend[k] = (m_st[k] == 1);
      e_rv[k]   = (m_st[k] == 2);
      e_stv[k]  = (m_st[k] == 1) && (m_age[k] == L);
      if (m_st[k] != 0) cnt++;
    end
    chk("req_ready",   32'(bus.req_ready),  32'(e_rdy));
    chk("pending",     32'(bus.pending),    32'(e_pend));
    chk("resp_valid",  32'(bus.resp_valid), 32'(e_rv));
    chk("starve",      32'(starve),         32'(e_stv));
    chk("outstanding", 32'(outstanding),    32'(cnt));
    chk("proto_err",   32'(proto_err),      32'(m_perr));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("slot_data%0d", k), 32'(bus.slot_data[k]), 32'(m_pay[k]));
      chk($sformatf("resp_data%0d", k), 32'(bus.resp_data[k]), 32'(m_res[k]));
    end
  endtask

  // inputs are set at the falling edge; check, clock, advance the model
  task automatic tick();
    #1;
    check_outputs();
    vectors++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.done       = '0;
    flush          = 1'b0;
    for (int k = 0; k < N; k++) begin
      bus.req_data[k] = 8'h00;
      bus.result[k]   = 8'h00;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clear_inputs();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick();
    chk("reset_ready", 32'(bus.req_ready), 32'h0000_000f);
    rst = 1'b0;

    // accept on ports 0 and 3
    bus.req_valid = 4'b1001; bus.req_data[0] = 8'h11; bus.req_data[3] = 8'h33;
    tick(); clear_inputs();
    chk("accept_pending", 32'(bus.pending), 32'h9);
    chk("accept_slot0",   32'(bus.slot_data[0]), 32'h11);
    chk("accept_cnt",     32'(outstanding), 32'd2);

    // complete port 0
    bus.done = 4'b0001; bus.result[0] = 8'hA0;
    tick(); clear_inputs();
    chk("done_rv",   32'(bus.resp_valid), 32'h1);
    chk("done_data", 32'(bus.resp_data[0]), 32'hA0);
    chk("done_pend", 32'(bus.pending), 32'h8);

    // drain and refill port 0 in one cycle
    bus.resp_ready[0] = 1'b1; bus.req_valid[0] = 1'b1; bus.req_data[0] = 8'h22;
    tick(); clear_inputs();
    chk("refill_pend", 32'(bus.pending), 32'h9);
    chk("refill_data", 32'(bus.slot_data[0]), 32'h22);
    chk("refill_cnt",  32'(outstanding), 32'd2);

    // put port 1 into DONE, then flush
    bus.req_valid[1] = 1'b1; bus.req_data[1] = 8'h44;
    tick(); clear_inputs();
    bus.done[1] = 1'b1; bus.result[1] = 8'h55;
    tick(); clear_inputs();
    flush = 1'b1;
    tick(); clear_inputs();
    chk("flush_pend", 32'(bus.pending), 32'h0);
    chk("flush_rv",   32'(bus.resp_valid), 32'h2);
    chk("flush_keep", 32'(bus.slot_data[3]), 32'h33);

    // flush and done together on port 3
    bus.req_valid[3] = 1'b1; bus.req_data[3] = 8'h66;
    tick(); clear_inputs();
    flush = 1'b1; bus.done[3] = 1'b1; bus.result[3] = 8'h77;
    tick(); clear_inputs();
    chk("flushdone_rv", 32'(bus.resp_valid), 32'ha);

    // starvation on port 2
    bus.req_valid[2] = 1'b1; bus.req_data[2] = 8'h88;
    tick(); clear_inputs();
    repeat (14) tick();
    chk("starve_before", 32'(starve), 32'h0);
    tick();
    chk("starve_at_limit", 32'(starve), 32'h4);
    bus.done[2] = 1'b1; bus.result[2] = 8'h99;
    tick(); clear_inputs();
    chk("starve_cleared", 32'(starve), 32'h0);

    // drain all, then done on empty port 1
    bus.resp_ready = 4'b1111;
    tick(); clear_inputs();
    bus.done = 4'b0010;
    tick(); clear_inputs();
    chk("perr_set",   32'(proto_err), 32'h1);
    chk("perr_state", 32'({bus.pending[1], bus.resp_valid[1]}), 32'h0);
    repeat (3) tick();
    chk("perr_sticky", 32'(proto_err), 32'h1);

    // randomized phase
    for (int c = 0; c < 600; c++) begin
      int pd;
      pd = ((c / 100) % 2 == 1) ? 3 : 40;
      rst = ($urandom_range(0, 127) == 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++) begin
        bus.req_valid[k]  = $urandom_range(0, 1) == 1;
        bus.req_data[k]   = 8'($urandom);
        bus.resp_ready[k] = $urandom_range(0, 2) == 0;
        bus.result[k]     = 8'($urandom);
        if (m_st[k] == 1) bus.done[k] = ($urandom_range(0, pd) == 0);
        else              bus.done[k] = ($urandom_range(0, 63) == 0);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
